sram_port_arbiter: RTL
======================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVATION_LIMIT, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have port clock  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port instruction_ram_request  in  1  fetch request, held until address_ready.
REQ-005 SHALL have port instruction_ram_size  in  2  fetch size.
REQ-006 SHALL have port instruction_ram_address  in  32  fetch address.
REQ-007 SHALL have port instruction_ram_read_data  out  32  fetch data, valid with instruction_ram_data_ready.
REQ-008 SHALL have port instruction_ram_address_ready  out  1  fetch address accepted.
REQ-009 SHALL have port instruction_ram_data_ready  out  1  fetch response.
REQ-010 SHALL have port data_ram_request  in  1  load/store request, held until address_ready.
REQ-011 SHALL have port data_ram_write  in  1  1 = store.
REQ-012 SHALL have port data_ram_size  in  2  access size.
REQ-013 SHALL have port data_ram_address  in  32  access address.
REQ-014 SHALL have port data_ram_write_data  in  32  store data.
REQ-015 SHALL have port data_ram_read_data  out  32  load data, valid with data_ram_data_ready.
REQ-016 SHALL have port data_ram_address_ready  out  1  access address accepted.
REQ-017 SHALL have port data_ram_data_ready  out  1  load data / store completion.
REQ-018 SHALL have port bus_request  out  1  request toward shared bridge.
REQ-019 SHALL have port bus_write  out  1  forwarded write flag (0 for fetches).
REQ-020 SHALL have port bus_size  out  2  forwarded size.
REQ-021 SHALL have port bus_address  out  32  forwarded address.
REQ-022 SHALL have port bus_write_data  out  32  forwarded store data (0 for fetches).
REQ-023 SHALL have port bus_read_data  in  32  bridge response data.
REQ-024 SHALL have port bus_address_ready  in  1  bridge accepted address.
REQ-025 SHALL have port bus_data_ready  in  1  bridge response.

Function
REQ-026 SHALL implement states IDLE, GRANT_DATA, GRANT_INSTRUCTION, WAIT_DATA, WAIT_INSTRUCTION; at most one transaction outstanding.
REQ-027 SHALL, in IDLE, register a grant for the next cycle: data wins, except instruction wins when starvation counter == STARVATION_LIMIT or no data request; no request -> stay IDLE.
REQ-028 SHALL, in GRANT_x, drive bus_* combinationally from requester x, bus_request = x's request; other requester sees address_ready = 0.
REQ-029 SHALL route bus_address_ready only to granted requester; on bus_request & bus_address_ready go to WAIT_x.
REQ-030 SHALL return GRANT_x -> IDLE if x's request drops before acceptance (protocol violation, no bus transfer).
REQ-031 SHALL, in WAIT_x, forward bus_data_ready only to x's data_ready, then go IDLE; bus_read_data passes to both read_data outputs unconditionally.
REQ-032 SHALL ignore bus_data_ready outside WAIT_x; new requests arriving with bus_data_ready arbitrate in the following IDLE cycle (one idle bubble per transaction).
REQ-033 SHALL increment starvation counter (width clog2(STARVATION_LIMIT+1), saturating) on each data grant with instruction request pending; clear on instruction grant or when instruction idle at arbitration.
REQ-034 SHALL keep bus_request = 0 in IDLE and WAIT_x; min transaction latency request->data_ready = 3 cycles with zero-wait bridge.

Reset
REQ-035 SHALL on reset force IDLE, counter 0, all ready outputs and bus_request/bus_write 0, bus_address/bus_write_data/bus_size 0; outstanding response discarded, never forwarded.
REQ-036 SHALL resume arbitration on the first clock edge after reset deasserts.

Structure
REQ-037 SHALL place ArbiterState enum and STARVATION_LIMIT default in package arbiter_params.
REQ-038 SHALL be one module, no sub-modules; counter and FSM inline.

Verification
REQ-039 SHALL test lone fetch 0xBFC00000, zero-wait bridge -> bus_address 0xBFC00000 in GRANT_INSTRUCTION, instruction_ram_data_ready 3 cycles after request, data 0x3C08BFAF.
REQ-040 SHALL test simultaneous fetch and store 0x80001000/0x12345678 -> store granted first, bus_write=1, fetch granted after store data_ready.
REQ-041 SHALL test continuous data requests plus pending fetch, LIMIT=4 -> exactly 4 data grants, then fetch granted.
REQ-042 SHALL test bus_data_ready pulsed in IDLE -> no data_ready on either port.
REQ-043 SHALL test reset asserted in WAIT_DATA -> IDLE immediately, later bus_data_ready not forwarded.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_params
//
// Purpose : shared definitions for the SRAM port arbiter, which merges the
//           instruction-fetch port and the load/store port of a CPU core
//           onto one bridge port.
//
// Contents:
//   STARVATION_LIMIT_DEFAULT - default number of back-to-back data grants
//                              allowed while a fetch is left waiting.
//   ArbiterState             - arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package arbiter_params;

   localparam int STARVATION_LIMIT_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE              = 3'd0,
      GRANT_DATA        = 3'd1,
      GRANT_INSTRUCTION = 3'd2,
      WAIT_DATA         = 3'd3,
      WAIT_INSTRUCTION  = 3'd4
   } ArbiterState;

endpackage : arbiter_params

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Purpose : two-master, one-slave arbiter in front of a shared memory bridge.
//           The data (load/store) port normally has priority.  A starvation
//           counter lets a waiting fetch through after STARVATION_LIMIT
//           consecutive data grants.  Only one transaction is in flight at a
//           time: arbitrate (IDLE) -> address phase (GRANT_x) -> response
//           phase (WAIT_x) -> IDLE.
//
// Parameters:
//   STARVATION_LIMIT  max consecutive data grants while a fetch waits
//
// Ports:
//   clock, reset                       rising-edge clock, async active-high reset
//   instruction_ram_request/size/address   fetch request side (inputs)
//   instruction_ram_read_data          fetch data, qualified by data_ready
//   instruction_ram_address_ready      fetch address accepted by the bridge
//   instruction_ram_data_ready         fetch response
//   data_ram_request/write/size/address/write_data   load/store side (inputs)
//   data_ram_read_data                 load data, qualified by data_ready
//   data_ram_address_ready             access address accepted by the bridge
//   data_ram_data_ready                load data / store completion
//   bus_request/write/size/address/write_data   forwarded request to bridge
//   bus_read_data                      bridge response data
//   bus_address_ready                  bridge accepted the address
//   bus_data_ready                     bridge response
// -----------------------------------------------------------------------------
module sram_port_arbiter
   import arbiter_params::*;
#(
   parameter int STARVATION_LIMIT = STARVATION_LIMIT_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        instruction_ram_request,
   input  logic [1:0]  instruction_ram_size,
   input  logic [31:0] instruction_ram_address,
   output logic [31:0] instruction_ram_read_data,
   output logic        instruction_ram_address_ready,
   output logic        instruction_ram_data_ready,

   input  logic        data_ram_request,
   input  logic        data_ram_write,
   input  logic [1:0]  data_ram_size,
   input  logic [31:0] data_ram_address,
   input  logic [31:0] data_ram_write_data,
   output logic [31:0] data_ram_read_data,
   output logic        data_ram_address_ready,
   output logic        data_ram_data_ready,

   output logic        bus_request,
   output logic        bus_write,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   input  logic [31:0] bus_read_data,
   input  logic        bus_address_ready,
   input  logic        bus_data_ready
);

   // A limit of 0 would give a zero-width counter; keep at least one bit.
   localparam int CNT_W = (STARVATION_LIMIT < 1) ? 1 : $clog2(STARVATION_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVATION_LIMIT);

   ArbiterState      state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;

   logic             fetch_starved;

   // Read data is broadcast; each requester qualifies it with its own
   // data_ready, so no muxing is needed here.
   assign instruction_ram_read_data = bus_read_data;
   assign data_ram_read_data        = bus_read_data;

   assign fetch_starved = instruction_ram_request && (starve_q == LIMIT_C);

   always_comb begin
      state_d                       = state_q;
      starve_d                      = starve_q;
      bus_request                   = 1'b0;
      bus_write                     = 1'b0;
      bus_size                      = 2'b00;
      bus_address                   = 32'h0;
      bus_write_data                = 32'h0;
      instruction_ram_address_ready = 1'b0;
      instruction_ram_data_ready    = 1'b0;
      data_ram_address_ready        = 1'b0;
      data_ram_data_ready           = 1'b0;

      case (state_q)
         IDLE: begin
            if (data_ram_request && !fetch_starved) begin
               state_d = GRANT_DATA;
               // Count only grants that actually make a fetch wait.  The
               // counter cannot already be at the limit here (that case
               // grants the fetch), so the increment never wraps.
               if (instruction_ram_request) begin
                  starve_d = starve_q + 1'b1;
               end else begin
                  starve_d = '0;
               end
            end else if (instruction_ram_request) begin
               state_d  = GRANT_INSTRUCTION;
               starve_d = '0;
            end else begin
               starve_d = '0;
            end
         end

         GRANT_DATA: begin
            bus_request            = data_ram_request;
            bus_write              = data_ram_write;
            bus_size               = data_ram_size;
            bus_address            = data_ram_address;
            bus_write_data         = data_ram_write_data;
            data_ram_address_ready = data_ram_request && bus_address_ready;
            if (data_ram_request && bus_address_ready) begin
               state_d = WAIT_DATA;
            end else if (!data_ram_request) begin
               // Requester withdrew before acceptance; nothing reached the bus.
               state_d = IDLE;
            end
         end

         GRANT_INSTRUCTION: begin
            bus_request                   = instruction_ram_request;
            bus_size                      = instruction_ram_size;
            bus_address                   = instruction_ram_address;
            instruction_ram_address_ready = instruction_ram_request && bus_address_ready;
            if (instruction_ram_request && bus_address_ready) begin
               state_d = WAIT_INSTRUCTION;
            end else if (!instruction_ram_request) begin
               state_d = IDLE;
            end
         end

         WAIT_DATA: begin
            data_ram_data_ready = bus_data_ready;
            if (bus_data_ready) begin
               state_d = IDLE;
            end
         end

         WAIT_INSTRUCTION: begin
            instruction_ram_data_ready = bus_data_ready;
            if (bus_data_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d  = IDLE;
            starve_d = '0;
         end
      endcase
   end

   // Reset returns straight to IDLE, so any response still owed by the
   // bridge lands in IDLE and is dropped rather than forwarded.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

endmodule : sram_port_arbiter
